graying_frame_ctrl: RTL
=======================

Name: graying_frame_ctrl

Overview:
- Frame-level sequencer for the pixel graying core.
- On `start`, streams one full RGB frame from a source pixel memory through the core, one pixel per clock.
- Holds the core enabled for the whole frame and writes each gray result to a destination memory at the matching address.
- Drops the core enable between frames so the core's ready counter restarts for every frame.

Parameters:
- color_width, 8, bits per colour channel and per gray sample
- im_width, 320, pixels per line
- im_height, 240, lines per frame
- addr_width, 17, memory address width; must satisfy 2^addr_width >= im_width*im_height
- core_latency, 2, clocks from a pixel on core_data to its result on core_gray (core mul_delay + 2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to process a frame; honoured only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE next cycle
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last gray write
- err  out  1  sticky; set when a write occurs while core_ready=0; cleared by start
- rd_en  out  1  source read strobe
- rd_addr  out  addr_width  source pixel address
- rd_data  in  3*color_width  source RGB, valid one clock after rd_en
- core_en  out  1  drives core in_enable
- core_data  out  3*color_width  drives core in_data; equals rd_data (combinational pass-through)
- core_ready  in  1  core out_ready
- core_gray  in  color_width  core out_data
- wr_en  out  1  destination write strobe
- wr_addr  out  addr_width  destination address
- wr_data  out  color_width  gray value, equals core_gray when wr_en=1, else 0

Behaviour:
- Reset: state IDLE; counters 0; all outputs 0.
- Constants: N = im_width*im_height, LAT = core_latency.
- FSM states:
  - IDLE: start -> STREAM; clears err and both counters.
  - STREAM: rd_en=1, rd_addr = rd_cnt, rd_cnt++ each cycle. When rd_cnt = N-1 is issued -> DRAIN.
  - DRAIN: rd_en=0; wait until wr_cnt reaches N -> DONE.
  - DONE: done=1 for one cycle, core_en=0 -> IDLE.
- Valid pipeline: shift register vpipe of depth LAT+1.
  - vpipe[0] = rd_en delayed 1 clock; this is the core-input-valid flag.
  - wr_en = vpipe[LAT].
  - wr_addr = wr_cnt; wr_cnt increments on each wr_en.
- core_en:
  - Registered; set the cycle the first rd_data arrives (vpipe[0] rising).
  - Held high continuously through DRAIN.
  - Cleared in DONE, IDLE and on abort.
- Timing (start sampled at cycle 0):
  - rd_addr k issued at cycle 1+k.
  - Pixel k on core_data at cycle 2+k.
  - wr_en for pixel k at cycle 2+k+LAT.
  - done at cycle N+2+LAT.
- err: set if wr_en=1 and core_ready=0; this flags a core_latency mismatch. The write still occurs.
- start while busy: ignored. start in the same cycle as DONE: ignored; the next start is accepted in IDLE.
- abort (any non-IDLE state):
  - Next cycle: IDLE, vpipe cleared, rd_en/wr_en/core_en 0, busy 0.
  - No done pulse; counters hold their values until the next start.
  - abort and start in the same cycle in IDLE: abort wins.
- Counters are sized addr_width. The last addresses are N-1; counters never wrap within a frame.
- rst_n asserted mid-frame: immediate return to the reset state; in-flight pixels are discarded.

Optional Feature:
- GRAY_SUM_EN
- Defined:
  - Adds output port gray_sum, width color_width+addr_width.
  - Accumulates wr_data on every wr_en; cleared when start is accepted.
  - Holds its final value from done until the next start.
- Undefined: port and accumulator are absent; all other behaviour is identical.

Decomposition:
- Package graying_pkg:
  - FSM state enum (IDLE, STREAM, DRAIN, DONE).
  - Default colour width.
  - Helper function for pixel count N.
- Sub-module: graying_valid_pipe, a parameterised depth-(LAT+1) valid shift register with synchronous clear, used for vpipe.

Test Plan (im_width=4, im_height=2, LAT=2, N=8, core model honouring LAT):
- Nominal frame: start at cycle 0 -> rd_addr 0..7 on cycles 1..8; wr_en on cycles 4..11 with wr_addr 0..7; done at cycle 12; busy high cycles 1..12.
- Data check: rd_data = {255,255,255} at address 3 -> wr_addr 3 carries wr_data = 254 (core arithmetic); pixel {0,0,0} -> 0.
- start pulsed at cycle 5 mid-frame -> ignored; exactly 8 writes and 1 done.
- abort at cycle 6 -> cycle 7: busy=0, core_en=0, no further wr_en, no done; a new start then yields a full 8-write frame starting at wr_addr 0.
- core model with latency 3 while LAT=2 -> err=1 after the first write; err cleared by the next start.
- GRAY_SUM_EN: all pixels {10,20,30} -> each write 18, gray_sum = 144 at done.

Source files
------------

// File: rtl/graying_pkg.sv
// graying_pkg: shared definitions for the graying frame controller.
//   state_e             - frame sequencer states
//   DEFAULT_COLOR_WIDTH - default bits per colour channel / gray sample
//   pixel_count()       - pixels per frame (im_width * im_height)
package graying_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_e;

    localparam int unsigned DEFAULT_COLOR_WIDTH = 8;

    function automatic int unsigned pixel_count(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

endpackage

// File: rtl/graying_valid_pipe.sv
// graying_valid_pipe: valid-flag shift register of configurable depth.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of every stage
//   din        : valid bit entering stage 0
//   dout       : valid bit leaving the last stage (depth clocks after din)
module graying_valid_pipe #(
    parameter int unsigned depth = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic din,
    output logic dout
);

    logic [depth-1:0] pipe_q;
    logic [depth-1:0] pipe_d;

    always_comb begin
        pipe_d = '0;
        if (!clr) begin
            pipe_d[0] = din;
            for (int unsigned i = 1; i < depth; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q[depth-1];

endmodule

// File: rtl/graying_frame_ctrl.sv
// graying_frame_ctrl: streams one RGB frame from a source memory through the
// graying core and writes each gray result to a destination memory.
//   start/abort/busy/done/err : frame control and status
//   rd_en/rd_addr/rd_data     : source pixel memory (data one clock after rd_en)
//   core_en/core_data         : core in_enable / in_data (rd_data pass-through)
//   core_ready/core_gray      : core out_ready / out_data
//   wr_en/wr_addr/wr_data     : destination gray memory
//   gray_sum                  : running sum of written gray values
// Optional build macro: GRAY_SUM_EN adds the gray_sum port and accumulator.
module graying_frame_ctrl
    import graying_pkg::*;
#(
    parameter int unsigned color_width  = DEFAULT_COLOR_WIDTH,
    parameter int unsigned im_width     = 320,
    parameter int unsigned im_height    = 240,
    parameter int unsigned addr_width   = 17,
    parameter int unsigned core_latency = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       rd_en,
    output logic [addr_width-1:0]      rd_addr,
    input  logic [3*color_width-1:0]   rd_data,
    output logic                       core_en,
    output logic [3*color_width-1:0]   core_data,
    input  logic                       core_ready,
    input  logic [color_width-1:0]     core_gray,
    output logic                       wr_en,
    output logic [addr_width-1:0]      wr_addr,
`ifdef GRAY_SUM_EN
    output logic [color_width+addr_width-1:0] gray_sum,
`endif
    output logic [color_width-1:0]     wr_data
);

    localparam int unsigned           N    = pixel_count(im_width, im_height);
    localparam logic [addr_width-1:0] LAST = addr_width'(N - 1);

    state_e                state_q, state_d;
    logic [addr_width-1:0] rd_cnt_q, rd_cnt_d;
    logic [addr_width-1:0] wr_cnt_q, wr_cnt_d;
    logic                  err_q, err_d;
    logic                  core_en_q, core_en_d;
    logic                  rd_en_w;
    logic                  wr_en_w;
    logic                  start_ok;

    assign rd_en_w  = (state_q == STREAM);
    assign start_ok = (state_q == IDLE) && start && !abort;

    // Tail of the depth core_latency+1 valid pipe: stage 0 marks a pixel on
    // core_data, the last stage marks its gray result on core_gray.
    graying_valid_pipe #(
        .depth(core_latency + 1)
    ) u_vpipe (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (abort),
        .din  (rd_en_w),
        .dout (wr_en_w)
    );

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        err_d    = err_q;

        if (wr_en_w) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (!core_ready) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d  = STREAM;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                    err_d    = 1'b0;
                end
            end
            STREAM: begin
                // Hold rd_cnt at the last address so it never wraps.
                if (rd_cnt_q == LAST) begin
                    state_d = DRAIN;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                // Leave on the last write so done lands the cycle after it.
                if (wr_en_w && (wr_cnt_q == LAST)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
        end

        // Rises together with the first pixel on core_data (one clock after the
        // first read) and stays up until the frame ends or is aborted.
        core_en_d = ((state_d == STREAM) || (state_d == DRAIN)) && (core_en_q || rd_en_w);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_q     <= 1'b0;
            core_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_q     <= err_d;
            core_en_q <= core_en_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign rd_en     = rd_en_w;
    assign rd_addr   = rd_en_w ? rd_cnt_q : '0;
    assign core_en   = core_en_q;
    assign core_data = rd_data;
    assign wr_en     = wr_en_w;
    assign wr_addr   = wr_cnt_q;
    assign wr_data   = wr_en_w ? core_gray : '0;

`ifdef GRAY_SUM_EN
    logic [color_width+addr_width-1:0] gray_sum_q, gray_sum_d;

    always_comb begin
        gray_sum_d = gray_sum_q;
        if (start_ok) begin
            gray_sum_d = '0;
        end else if (wr_en_w) begin
            gray_sum_d = gray_sum_q + (color_width + addr_width)'(wr_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_sum_q <= '0;
        end else begin
            gray_sum_q <= gray_sum_d;
        end
    end

    assign gray_sum = gray_sum_q;
`endif

endmodule
